// File: rtl/readout_pkg.sv
// ---------------------------------------------------------------------------
// readout_pkg
// Shared types and helpers for the qubit readout shot sequencer.
//   seq_state_t : sequencer FSM state encoding
//   SHOT_W_DEF  : default shot counter width
//   ACC_W_DEF   : default accumulator width (32-bit sample + 16 bits growth)
//   sext()      : sign-extend a 32-bit integrator sample to ACC_W_DEF bits
// ---------------------------------------------------------------------------
package readout_pkg;

    localparam int SHOT_W_DEF = 16;
    localparam int ACC_W_DEF  = 48;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG     = 3'd1,
        ST_ARM     = 3'd2,
        ST_WAIT_IQ = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

    function automatic logic signed [ACC_W_DEF-1:0] sext(input logic [31:0] i_x);
        return {{(ACC_W_DEF-32){i_x[31]}}, i_x};
    endfunction

endpackage

// File: rtl/shot_accumulator.sv
// ---------------------------------------------------------------------------
// shot_accumulator
// One signed running sum with synchronous clear and add enables.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset (sum forced to 0)
//   i_clr   : clear the sum to 0
//   i_add   : add i_data to the sum
//   i_data  : signed, already sign-extended addend
//   o_acc   : registered signed sum
// ---------------------------------------------------------------------------
module shot_accumulator
    import readout_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic                    i_add,
    input  logic signed [ACC_W-1:0] i_data,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] r_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + i_data;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/readout_sequencer.sv
// ---------------------------------------------------------------------------
// readout_sequencer
// Shot-level controller for the readout chain: fires one trigger per shot,
// waits for the integrator result, accumulates I/Q over N shots and hands the
// sums out through a valid/ready handshake. Configuration updates are only
// applied between runs.
//
// State      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start or a configuration update request
// ST_CFG     | one-cycle config_reset / ack pulse
// ST_ARM     | one-cycle trigger pulse for the current shot
// ST_WAIT_IQ | waiting for iq_valid, timeout counter running
// ST_GAP     | repetition gap between shots
// ST_DONE    | sums valid, waiting for sum_ready
//
// Ports:
//   i_clk100, i_reset_n          : clock, async active-low reset
//   i_start, i_abort             : run control
//   i_num_shots, i_rep_gap       : run parameters, latched at start
//   i_cfg_update_req / o_cfg_update_ack, o_config_reset : config handshake
//   o_trigger                    : per-shot trigger pulse
//   i_iq_valid, i_i_val, i_q_val : integrator result
//   o_busy, o_shot_idx, o_timeout_err : status
//   o_i_sum, o_q_sum, o_sum_valid, i_sum_ready : result handshake
// ---------------------------------------------------------------------------
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int SHOT_W         = SHOT_W_DEF,
    parameter int ACC_W          = ACC_W_DEF,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GAP_W          = 16
) (
    input  logic                    i_clk100,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [SHOT_W-1:0]       i_num_shots,
    input  logic [GAP_W-1:0]        i_rep_gap,
    input  logic                    i_cfg_update_req,
    output logic                    o_cfg_update_ack,
    output logic                    o_config_reset,
    output logic                    o_trigger,
    input  logic                    i_iq_valid,
    input  logic [31:0]             i_i_val,
    input  logic [31:0]             i_q_val,
    output logic                    o_busy,
    output logic [SHOT_W-1:0]       o_shot_idx,
    output logic                    o_timeout_err,
    output logic signed [ACC_W-1:0] o_i_sum,
    output logic signed [ACC_W-1:0] o_q_sum,
    output logic                    o_sum_valid,
    input  logic                    i_sum_ready
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t        r_state;
    logic              r_trigger;
    logic              r_cfg_ack;
    logic              r_config_reset;
    logic              r_busy;
    logic              r_timeout_err;
    logic              r_sum_valid;
    logic              r_start_pend;
    logic [SHOT_W-1:0] r_shot_idx;
    logic [SHOT_W-1:0] r_num_shots;
    logic [GAP_W-1:0]  r_rep_gap;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [TO_W-1:0]   r_to_cnt;

    logic              w_start_ok;
    logic              w_acc_clr;
    logic              w_acc_add;
    logic [SHOT_W-1:0] w_shot_next;
    logic signed [ACC_W-1:0] w_i_ext;
    logic signed [ACC_W-1:0] w_q_ext;

    assign w_start_ok  = i_start && (i_num_shots != '0);
    // Sums are cleared when the run is accepted, even if a config pulse runs first.
    assign w_acc_clr   = (r_state == ST_IDLE) && w_start_ok;
    // abort beats a coincident iq_valid.
    assign w_acc_add   = (r_state == ST_WAIT_IQ) && i_iq_valid && !i_abort;
    assign w_shot_next = r_shot_idx + SHOT_W'(1);
    assign w_i_ext     = ACC_W'(sext(i_i_val));
    assign w_q_ext     = ACC_W'(sext(i_q_val));

    always_ff @(posedge i_clk100 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_trigger      <= 1'b0;
            r_cfg_ack      <= 1'b0;
            r_config_reset <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_sum_valid    <= 1'b0;
            r_start_pend   <= 1'b0;
            r_shot_idx     <= '0;
            r_num_shots    <= '0;
            r_rep_gap      <= '0;
            r_gap_cnt      <= '0;
            r_to_cnt       <= '0;
        end else begin
            r_trigger      <= 1'b0;
            r_cfg_ack      <= 1'b0;
            r_config_reset <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_num_shots   <= i_num_shots;
                        r_rep_gap     <= i_rep_gap;
                        r_shot_idx    <= '0;
                        r_timeout_err <= 1'b0;
                    end
                    if (i_cfg_update_req) begin
                        r_state        <= ST_CFG;
                        r_busy         <= 1'b1;
                        r_cfg_ack      <= 1'b1;
                        r_config_reset <= 1'b1;
                        r_start_pend   <= w_start_ok;
                    end else if (w_start_ok) begin
                        r_state   <= ST_ARM;
                        r_busy    <= 1'b1;
                        r_trigger <= 1'b1;
                    end
                end

                ST_CFG: begin
                    r_start_pend <= 1'b0;
                    if (r_start_pend) begin
                        r_state   <= ST_ARM;
                        r_trigger <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_ARM: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state  <= ST_WAIT_IQ;
                        r_to_cnt <= '0;
                    end
                end

                ST_WAIT_IQ: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_iq_valid) begin
                        r_shot_idx <= w_shot_next;
                        if (w_shot_next == r_num_shots) begin
                            r_state     <= ST_DONE;
                            r_sum_valid <= 1'b1;
                        end else if (r_rep_gap == '0) begin
                            r_state   <= ST_ARM;
                            r_trigger <= 1'b1;
                        end else begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= r_rep_gap - GAP_W'(1);
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state       <= ST_DONE;
                        r_sum_valid   <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                ST_GAP: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_gap_cnt == '0) begin
                        r_state   <= ST_ARM;
                        r_trigger <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                ST_DONE: begin
                    if (i_sum_ready) begin
                        r_state     <= ST_IDLE;
                        r_sum_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_sum_valid <= 1'b0;
                end
            endcase
        end
    end

    shot_accumulator #(.ACC_W(ACC_W)) u_acc_i (
        .i_clk   (i_clk100),
        .i_rst_n (i_reset_n),
        .i_clr   (w_acc_clr),
        .i_add   (w_acc_add),
        .i_data  (w_i_ext),
        .o_acc   (o_i_sum)
    );

    shot_accumulator #(.ACC_W(ACC_W)) u_acc_q (
        .i_clk   (i_clk100),
        .i_rst_n (i_reset_n),
        .i_clr   (w_acc_clr),
        .i_add   (w_acc_add),
        .i_data  (w_q_ext),
        .o_acc   (o_q_sum)
    );

    assign o_trigger        = r_trigger;
    assign o_cfg_update_ack = r_cfg_ack;
    assign o_config_reset   = r_config_reset;
    assign o_busy           = r_busy;
    assign o_shot_idx       = r_shot_idx;
    assign o_timeout_err    = r_timeout_err;
    assign o_sum_valid      = r_sum_valid;

endmodule

// File: tb/tb_readout_sequencer.sv
module tb_readout_sequencer;

    localparam int SHOT_W = 16;
    localparam int ACC_W  = 48;
    localparam int GAP_W  = 16;
    localparam int TMO    = 20;

    logic              clk100         = 1'b0;
    logic              reset_n        = 1'b0;
    logic              start          = 1'b0;
    logic              abort          = 1'b0;
    logic [SHOT_W-1:0] num_shots      = '0;
    logic [GAP_W-1:0]  rep_gap        = '0;
    logic              cfg_update_req = 1'b0;
    logic              iq_valid       = 1'b0;
    logic [31:0]       i_val          = '0;
    logic [31:0]       q_val          = '0;
    logic              sum_ready      = 1'b0;

    logic                    cfg_update_ack;
    logic                    config_reset;
    logic                    trigger;
    logic                    busy;
    logic [SHOT_W-1:0]       shot_idx;
    logic                    timeout_err;
    logic signed [ACC_W-1:0] i_sum;
    logic signed [ACC_W-1:0] q_sum;
    logic                    sum_valid;

    int vectors     = 0;
    int miscompares = 0;
    int trig_cnt    = 0;
    int cfgrst_cnt  = 0;
    int sv_cycles   = 0;

    readout_sequencer #(
        .SHOT_W(SHOT_W), .ACC_W(ACC_W), .TIMEOUT_CYCLES(TMO), .GAP_W(GAP_W)
    ) dut (
        .i_clk100         (clk100),
        .i_reset_n        (reset_n),
        .i_start          (start),
        .i_abort          (abort),
        .i_num_shots      (num_shots),
        .i_rep_gap        (rep_gap),
        .i_cfg_update_req (cfg_update_req),
        .o_cfg_update_ack (cfg_update_ack),
        .o_config_reset   (config_reset),
        .o_trigger        (trigger),
        .i_iq_valid       (iq_valid),
        .i_i_val          (i_val),
        .i_q_val          (q_val),
        .o_busy           (busy),
        .o_shot_idx       (shot_idx),
        .o_timeout_err    (timeout_err),
        .o_i_sum          (i_sum),
        .o_q_sum          (q_sum),
        .o_sum_valid      (sum_valid),
        .i_sum_ready      (sum_ready)
    );

    always #5 clk100 = ~clk100;

    always @(negedge clk100) begin
        if (trigger)      trig_cnt++;
        if (config_reset) cfgrst_cnt++;
        if (sum_valid)    sv_cycles++;
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called in a trigger cycle: returns iq_valid 'dly' cycles later.
    task automatic shot(input int dly, input logic [31:0] iv, input logic [31:0] qv);
        repeat (dly) tick();
        iq_valid = 1'b1;
        i_val    = iv;
        q_val    = qv;
        tick();
        iq_valid = 1'b0;
    endtask

    task automatic wait_trig(output int n);
        n = 0;
        while (trigger !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int t0;
        int sv0;

        // reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_trigger", trigger, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_i_sum", i_sum, 0);
        chk("rst_shot_idx", shot_idx, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset_n = 1'b1;
        tick();

        // 1: four shots, gap 3, iq 10 cycles after each trigger
        num_shots = 4; rep_gap = 3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_trig0", trigger, 1);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                wait_trig(n);
                chk("t1_trig_seen", trigger, 1);
                chk("t1_trig_spacing", 11 + n, 14);
            end
            shot(10, 32'd100, -32'sd50);
        end
        chk("t1_sum_valid", sum_valid, 1);
        chk("t1_i_sum", i_sum, 400);
        chk("t1_q_sum", q_sum, -200);
        chk("t1_shot_idx", shot_idx, 4);
        chk("t1_trig_cnt", trig_cnt, 4);
        repeat (5) tick();
        chk("t1_hold_valid", sum_valid, 1);
        chk("t1_hold_i_sum", i_sum, 400);
        chk("t1_hold_busy", busy, 1);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("t1_valid_drop", sum_valid, 0);
        chk("t1_idle_busy", busy, 0);

        // 2: zero-shot start ignored; config request held off during a run
        num_shots = 0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_zero_busy", busy, 0);
        chk("t2_zero_trig", trigger, 0);
        repeat (3) tick();
        chk("t2_zero_trig_cnt", trig_cnt, 4);
        num_shots = 2; rep_gap = 0; start = 1'b1;
        tick();
        start = 1'b0;
        cfg_update_req = 1'b1;
        chk("t2_trig0", trigger, 1);
        shot(3, 32'd7, -32'sd3);
        chk("t2_gap0_trig", trigger, 1);
        shot(3, 32'd7, -32'sd3);
        chk("t2_sum_valid", sum_valid, 1);
        chk("t2_i_sum", i_sum, 14);
        chk("t2_q_sum", q_sum, -6);
        chk("t2_no_cfg_in_run", cfgrst_cnt, 0);
        repeat (2) tick();
        chk("t2_no_cfg_in_done", cfgrst_cnt, 0);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("t2_valid_drop", sum_valid, 0);
        chk("t2_cfg_not_yet", config_reset, 0);
        tick();
        chk("t2_config_reset", config_reset, 1);
        chk("t2_cfg_ack", cfg_update_ack, 1);
        chk("t2_cfg_busy", busy, 1);
        cfg_update_req = 1'b0;
        tick();
        chk("t2_cfg_done_busy", busy, 0);
        chk("t2_cfg_ack_drop", cfg_update_ack, 0);
        chk("t2_cfgrst_cnt", cfgrst_cnt, 1);

        // 3: start and cfg request in the same cycle
        num_shots = 1; rep_gap = 0; start = 1'b1; cfg_update_req = 1'b1;
        tick();
        start = 1'b0; cfg_update_req = 1'b0;
        chk("t3_config_reset", config_reset, 1);
        chk("t3_cfg_ack", cfg_update_ack, 1);
        chk("t3_no_trig_yet", trigger, 0);
        tick();
        chk("t3_trig_after_cfg", trigger, 1);
        chk("t3_cfg_drop", config_reset, 0);
        shot(2, 32'd5, 32'd5);
        chk("t3_sum_valid", sum_valid, 1);
        chk("t3_i_sum", i_sum, 5);
        chk("t3_shot_idx", shot_idx, 1);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;

        // 4: timeout after the second trigger
        num_shots = 3; rep_gap = 2; start = 1'b1;
        tick();
        start = 1'b0;
        shot(2, 32'd11, -32'sd22);
        wait_trig(n);
        chk("t4_trig2", trigger, 1);
        n = 0;
        while (sum_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("t4_sum_valid", sum_valid, 1);
        chk("t4_tmo_window", (n >= TMO && n <= TMO + 2) ? 1 : 0, 1);
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_shot_idx", shot_idx, 1);
        chk("t4_i_sum", i_sum, 11);
        chk("t4_q_sum", q_sum, -22);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("t4_err_sticky", timeout_err, 1);
        num_shots = 1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_err_cleared", timeout_err, 0);
        tick();
        abort = 1'b1; iq_valid = 1'b1; i_val = 32'd50;
        tick();
        abort = 1'b0; iq_valid = 1'b0;
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_no_acc", i_sum, 0);
        chk("t4_abort_no_count", shot_idx, 0);
        chk("t4_abort_no_valid", sum_valid, 0);

        // 5: abort in GAP, then stray iq_valid in IDLE
        num_shots = 5; rep_gap = 4; start = 1'b1;
        tick();
        start = 1'b0;
        shot(2, 32'd1, 32'd1);
        wait_trig(n);
        chk("t5_gap_len", n, 4);
        shot(2, 32'd1, 32'd1);
        chk("t5_in_gap_busy", busy, 1);
        t0  = trig_cnt;
        sv0 = sv_cycles;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_shot_idx", shot_idx, 2);
        chk("t5_i_sum_kept", i_sum, 2);
        repeat (15) tick();
        chk("t5_no_trigger", trig_cnt, t0);
        chk("t5_no_sum_valid", sv_cycles, sv0);
        iq_valid = 1'b1; i_val = 32'd1000;
        tick();
        iq_valid = 1'b0;
        tick();
        chk("t5_stray_i_sum", i_sum, 2);
        chk("t5_stray_shot_idx", shot_idx, 2);
        chk("t5_stray_busy", busy, 0);

        // 6: async reset mid-WAIT_IQ, then sign extension
        num_shots = 2; rep_gap = 0; start = 1'b1;
        tick();
        start = 1'b0;
        shot(2, 32'd9, 32'd9);
        tick();
        chk("t6_pre_i_sum", i_sum, 9);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_i_sum", i_sum, 0);
        chk("t6_rst_q_sum", q_sum, 0);
        chk("t6_rst_shot_idx", shot_idx, 0);
        chk("t6_rst_trigger", trigger, 0);
        chk("t6_rst_sum_valid", sum_valid, 0);
        tick();
        reset_n = 1'b1;
        tick();
        num_shots = 2; rep_gap = 0; start = 1'b1;
        tick();
        start = 1'b0;
        shot(2, 32'h8000_0000, 32'd0);
        shot(2, 32'h8000_0000, 32'd0);
        chk("t6_sum_valid", sum_valid, 1);
        chk("t6_i_sum_sext", i_sum, -64'sd4294967296);
        chk("t6_q_sum", q_sum, 0);
        chk("t6_shot_idx", shot_idx, 2);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("t6_final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
